// File: rtl/updown_count_ctrl.sv
// Run/pause/direction controller: FSM-gated prescaler producing a tick that steps a modulo up/down counter.
// Define UPDOWN_BOUNCE_EN to make the counter reverse direction at either end instead of wrapping.
module updown_count_ctrl #(
  parameter int COUNT_WIDTH = 24,
  parameter int TICK_MAX    = 6000000 - 1,
  parameter int VALUE_WIDTH = 4,
  parameter int VALUE_MAX   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_stop,
  input  logic                   dir_toggle,
  input  logic                   clear,
  input  logic                   load,
  input  logic [VALUE_WIDTH-1:0] load_value,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   tick,
  output logic                   wrap,
  output logic                   running,
  output logic                   dir_up
);

  localparam logic [COUNT_WIDTH:0]   TICK_LIMIT = (COUNT_WIDTH + 1)'(TICK_MAX);
  localparam logic [VALUE_WIDTH-1:0] VALUE_TOP  = VALUE_WIDTH'(VALUE_MAX);
  localparam logic [VALUE_WIDTH-1:0] VALUE_ONE  = VALUE_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH:0]   prescaler;
  logic [COUNT_WIDTH:0]   prescaler_next;
  logic [VALUE_WIDTH-1:0] value_next;
  logic                   tick_next;
  logic                   wrap_next;
  logic                   dir_next;
  logic [VALUE_WIDTH-1:0] step_value;
  logic                   step_wrap;
  logic [VALUE_WIDTH-1:0] load_clamped;
  logic                   terminal;
`ifdef UPDOWN_BOUNCE_EN
  logic                   step_dir;
`endif

  assign running      = (state == RUN);
  assign terminal     = (prescaler == TICK_LIMIT);
  assign load_clamped = (load_value > VALUE_TOP) ? VALUE_TOP : load_value;

  // Candidate next value if a step happens this cycle, always using the current direction.
  always_comb begin
    step_value = value;
    step_wrap  = 1'b0;
`ifdef UPDOWN_BOUNCE_EN
    step_dir   = dir_up;
`endif
    if (dir_up) begin
      if (value == VALUE_TOP) begin
        step_wrap = 1'b1;
`ifdef UPDOWN_BOUNCE_EN
        step_value = VALUE_TOP - VALUE_ONE;
        step_dir   = 1'b0;
`else
        step_value = '0;
`endif
      end else begin
        step_value = value + VALUE_ONE;
      end
    end else begin
      if (value == '0) begin
        step_wrap = 1'b1;
`ifdef UPDOWN_BOUNCE_EN
        step_value = VALUE_ONE;
        step_dir   = 1'b1;
`else
        step_value = VALUE_TOP;
`endif
      end else begin
        step_value = value - VALUE_ONE;
      end
    end
  end

  // clear overrides load, which overrides the normal FSM/prescaler behaviour.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    value_next     = value;
    tick_next      = 1'b0;
    wrap_next      = 1'b0;
    dir_next       = dir_toggle ? ~dir_up : dir_up;

    case (state)
      IDLE: begin
        prescaler_next = '0;
        if (start_stop) state_next = RUN;
      end
      RUN: begin
        if (terminal) begin
          prescaler_next = '0;
          tick_next      = 1'b1;
          wrap_next      = step_wrap;
          value_next     = step_value;
`ifdef UPDOWN_BOUNCE_EN
          if (step_wrap) dir_next = step_dir;
`endif
        end else begin
          prescaler_next = prescaler + 1'b1;
        end
        if (start_stop) state_next = HOLD;
      end
      HOLD: begin
        if (start_stop) state_next = RUN;
      end
      default: begin
        state_next     = IDLE;
        prescaler_next = '0;
      end
    endcase

    if (clear) begin
      state_next     = IDLE;
      prescaler_next = '0;
      value_next     = '0;
      tick_next      = 1'b0;
      wrap_next      = 1'b0;
      dir_next       = 1'b1;
    end else if (load) begin
      state_next     = state;
      prescaler_next = '0;
      value_next     = load_clamped;
      tick_next      = 1'b0;
      wrap_next      = 1'b0;
      dir_next       = dir_toggle ? ~dir_up : dir_up;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      value     <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      dir_up    <= 1'b1;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      value     <= value_next;
      tick      <= tick_next;
      wrap      <= wrap_next;
      dir_up    <= dir_next;
    end
  end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Scenario bench for updown_count_ctrl with TICK_MAX=3, VALUE_WIDTH=3, VALUE_MAX=5.
module tb_updown_count_ctrl;
  localparam int VW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_stop = 1'b0;
  logic          dir_toggle = 1'b0;
  logic          clear = 1'b0;
  logic          load = 1'b0;
  logic [VW-1:0] load_value = '0;
  logic [VW-1:0] value;
  logic          tick;
  logic          wrap;
  logic          running;
  logic          dir_up;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [VW-1:0] val;
    logic          wrp;
    logic          dir;
  } exp_t;
  exp_t sb[$];

  updown_count_ctrl #(
    .COUNT_WIDTH(24),
    .TICK_MAX(3),
    .VALUE_WIDTH(VW),
    .VALUE_MAX(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_stop(start_stop),
    .dir_toggle(dir_toggle),
    .clear(clear),
    .load(load),
    .load_value(load_value),
    .value(value),
    .tick(tick),
    .wrap(wrap),
    .running(running),
    .dir_up(dir_up)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (tick !== 1'b1 && n < 40);
    if (tick !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    total++; if (value !== 3'd0) begin bad++; $display("FAIL reset_value got=%0d want=0", value); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b want=0", tick); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b want=0", wrap); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%0b want=0", running); end
    total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL reset_dir got=%0b want=1", dir_up); end
  endtask

  task automatic test_count_up();
    exp_t e;
    int   n;
    int   gap;
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    total++; if (running !== 1'b1) begin bad++; $display("FAIL start_running got=%0b want=1", running); end
    for (int v = 1; v <= 5; v++) sb.push_back('{VW'(v), 1'b0, 1'b1});
`ifdef UPDOWN_BOUNCE_EN
    sb.push_back('{3'd4, 1'b1, 1'b0});
`else
    sb.push_back('{3'd0, 1'b1, 1'b1});
`endif
    gap = 4;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(n);
      total++; if (n !== gap) begin bad++; $display("FAIL up_gap got=%0d want=%0d", n, gap); end
      total++; if (value !== e.val) begin bad++; $display("FAIL up_value got=%0d want=%0d", value, e.val); end
      total++; if (wrap !== e.wrp) begin bad++; $display("FAIL up_wrap got=%0b want=%0b", wrap, e.wrp); end
      total++; if (dir_up !== e.dir) begin bad++; $display("FAIL up_dir got=%0b want=%0b", dir_up, e.dir); end
      cycle();
      total++; if ({tick, wrap} !== 2'b00) begin bad++; $display("FAIL up_pulse_width got=%0b want=0", {tick, wrap}); end
      gap = 3;
    end
  endtask

  task automatic test_down();
    exp_t e;
    int   n;
    int   gap;
    dir_toggle = 1'b1; cycle(); dir_toggle = 1'b0;
    total++; if (dir_up !== 1'b0) begin bad++; $display("FAIL toggle_dir got=%0b want=0", dir_up); end
    sb.push_back('{3'd5, 1'b1, 1'b0});
    sb.push_back('{3'd4, 1'b0, 1'b0});
    sb.push_back('{3'd3, 1'b0, 1'b0});
    gap = 2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(n);
      total++; if (n !== gap) begin bad++; $display("FAIL down_gap got=%0d want=%0d", n, gap); end
      total++; if (value !== e.val) begin bad++; $display("FAIL down_value got=%0d want=%0d", value, e.val); end
      total++; if (wrap !== e.wrp) begin bad++; $display("FAIL down_wrap got=%0b want=%0b", wrap, e.wrp); end
      gap = 4;
    end
    cycle(); cycle(); cycle();
    dir_toggle = 1'b1; cycle(); dir_toggle = 1'b0;
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL toggle_tick got=%0b want=1", tick); end
    total++; if (value !== 3'd2) begin bad++; $display("FAIL toggle_old_dir got=%0d want=2", value); end
    total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL toggle_new_dir got=%0b want=1", dir_up); end
  endtask

`ifdef UPDOWN_BOUNCE_EN
  task automatic test_bounce();
    exp_t e;
    int   n;
    rst = 1'b1; cycle(); rst = 1'b0;
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    for (int v = 1; v <= 5; v++) sb.push_back('{VW'(v), 1'b0, 1'b1});
    sb.push_back('{3'd4, 1'b1, 1'b0});
    for (int v = 3; v >= 0; v--) sb.push_back('{VW'(v), 1'b0, 1'b0});
    sb.push_back('{3'd1, 1'b1, 1'b1});
    sb.push_back('{3'd2, 1'b0, 1'b1});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_tick(n);
      total++; if (n !== 4) begin bad++; $display("FAIL bounce_gap got=%0d want=4", n); end
      total++; if (value !== e.val) begin bad++; $display("FAIL bounce_value got=%0d want=%0d", value, e.val); end
      total++; if (wrap !== e.wrp) begin bad++; $display("FAIL bounce_wrap got=%0b want=%0b", wrap, e.wrp); end
      total++; if (dir_up !== e.dir) begin bad++; $display("FAIL bounce_dir got=%0b want=%0b", dir_up, e.dir); end
    end
  endtask
`endif

  task automatic test_hold();
    int n;
    rst = 1'b1; cycle(); rst = 1'b0;
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    wait_tick(n);
    total++; if (n !== 4) begin bad++; $display("FAIL hold_first_gap got=%0d want=4", n); end
    cycle();
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL hold_running got=%0b want=0", running); end
    repeat (10) begin
      cycle();
      total++; if ({tick, value} !== {1'b0, 3'd1}) begin bad++; $display("FAIL hold_frozen got=%0d want=1", {tick, value}); end
    end
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running got=%0b want=1", running); end
    wait_tick(n);
    total++; if (n !== 2) begin bad++; $display("FAIL resume_gap got=%0d want=2", n); end
    total++; if (value !== 3'd2) begin bad++; $display("FAIL resume_value got=%0d want=2", value); end
  endtask

  task automatic test_load();
    int n;
    load = 1'b1; load_value = 3'd1; start_stop = 1'b1; cycle();
    load = 1'b0; start_stop = 1'b0;
    total++; if (value !== 3'd1) begin bad++; $display("FAIL load_value got=%0d want=1", value); end
    total++; if (running !== 1'b1) begin bad++; $display("FAIL load_ignores_start got=%0b want=1", running); end
    load = 1'b1; load_value = 3'd7; cycle(); load = 1'b0;
    total++; if (value !== 3'd5) begin bad++; $display("FAIL load_clamp got=%0d want=5", value); end
    cycle(); cycle(); cycle();
    load = 1'b1; load_value = 3'd2; cycle(); load = 1'b0;
    total++; if (value !== 3'd2) begin bad++; $display("FAIL load_terminal_value got=%0d want=2", value); end
    total++; if ({tick, wrap} !== 2'b00) begin bad++; $display("FAIL load_terminal_tick got=%0b want=0", {tick, wrap}); end
    wait_tick(n);
    total++; if (n !== 4) begin bad++; $display("FAIL load_gap got=%0d want=4", n); end
    total++; if (value !== 3'd3) begin bad++; $display("FAIL load_next_value got=%0d want=3", value); end
  endtask

  task automatic test_clear();
    dir_toggle = 1'b1; cycle(); dir_toggle = 1'b0;
    total++; if (dir_up !== 1'b0) begin bad++; $display("FAIL pre_clear_dir got=%0b want=0", dir_up); end
    clear = 1'b1; dir_toggle = 1'b1; cycle(); clear = 1'b0; dir_toggle = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL clear_running got=%0b want=0", running); end
    total++; if (value !== 3'd0) begin bad++; $display("FAIL clear_value got=%0d want=0", value); end
    total++; if (dir_up !== 1'b1) begin bad++; $display("FAIL clear_dir got=%0b want=1", dir_up); end
    repeat (6) begin
      cycle();
      total++; if ({tick, wrap, value} !== 5'd0) begin bad++; $display("FAIL idle_quiet got=%0d want=0", {tick, wrap, value}); end
    end
  endtask

  task automatic test_rst_hold();
    int n;
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    wait_tick(n);
    total++; if (value !== 3'd1) begin bad++; $display("FAIL rst_pre_value got=%0d want=1", value); end
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    dir_toggle = 1'b1; cycle(); dir_toggle = 1'b0;
    total++; if ({running, dir_up} !== 2'b00) begin bad++; $display("FAIL hold_toggle got=%0b want=0", {running, dir_up}); end
    rst = 1'b1; cycle(); rst = 1'b0;
    total++; if ({value, tick, wrap, running, dir_up} !== 7'b0000001) begin bad++; $display("FAIL rst_hold got=%0b want=1", {value, tick, wrap, running, dir_up}); end
    start_stop = 1'b1; cycle(); start_stop = 1'b0;
    wait_tick(n);
    total++; if (n !== 4) begin bad++; $display("FAIL rst_restart_gap got=%0d want=4", n); end
    total++; if (value !== 3'd1) begin bad++; $display("FAIL rst_restart_value got=%0d want=1", value); end
  endtask

  initial begin
    test_reset();
    test_count_up();
`ifdef UPDOWN_BOUNCE_EN
    test_bounce();
`else
    test_down();
`endif
    test_hold();
    test_load();
    test_clear();
    test_rst_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/updown_count_ctrl.md
Name: updown_count_ctrl

Overview:
- Run/pause/direction controller for the up/down counter demo; replaces a free-running divided clock with a single-clock tick enable.
- Owns an internal prescaler that is enabled, held or cleared by an FSM, and steps a VALUE_WIDTH counter up or down, modulo VALUE_MAX+1, on each tick.
- Inputs are single-cycle pulses from upstream button debouncers.
- Outputs feed the display/LED logic.

Parameters:
- COUNT_WIDTH, 24: prescaler width minus 1; the prescaler register is COUNT_WIDTH+1 bits.
- TICK_MAX, 6000000-1: prescaler terminal value; tick period is TICK_MAX+1 RUN-state cycles. Width COUNT_WIDTH+1.
- VALUE_WIDTH, 4: counter value width.
- VALUE_MAX, 9: highest counter value; must be ≥1 and ≤ 2^VALUE_WIDTH-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start_stop  input  1  pulse: IDLE→RUN, RUN→HOLD, HOLD→RUN.
- dir_toggle  input  1  pulse: invert count direction.
- clear  input  1  pulse: return to IDLE, value 0.
- load  input  1  pulse: load load_value.
- load_value  input  VALUE_WIDTH  value to load.
- value  output  VALUE_WIDTH  current count (registered).
- tick  output  1  one-cycle pulse, coincident with each value step.
- wrap  output  1  one-cycle pulse when a step crosses an end (VALUE_MAX↔0).
- running  output  1  high in RUN state.
- dir_up  output  1  1 = counting up, 0 = counting down.

Behaviour:
- All logic is on posedge clk only. Reset is synchronous.
- Reset values: state=IDLE, prescaler=0, value=0, tick=0, wrap=0, running=0, dir_up=1.
- FSM states: IDLE, RUN, HOLD.
  - IDLE: prescaler forced to 0.
  - RUN: prescaler counts.
  - HOLD: prescaler frozen at its current value; resume continues from it, with no restart of the period.
- Prescaler in RUN: if prescaler==TICK_MAX, then prescaler←0, tick←1 and value steps at this same edge; otherwise prescaler+1 and tick←0.
  - tick and the new value are visible in the same cycle, one cycle after the terminal count.
  - The first tick after IDLE→RUN appears TICK_MAX+1 clocks after the cycle in which running first reads 1.
- Step rules:
  - Up: value==VALUE_MAX → 0 with wrap=1; otherwise value+1.
  - Down: value==0 → VALUE_MAX with wrap=1; otherwise value-1.
- tick and wrap are 0 in every non-step cycle, and always 0 in IDLE and HOLD.
- start_stop in a RUN cycle: that cycle still counts and may tick; state becomes HOLD at that edge.
- dir_toggle: dir_up inverts at the edge. A step at the same edge uses the old direction. Accepted in any state.
- Priority of events at the same edge: clear > load > start_stop.
  - clear: state←IDLE, prescaler←0, value←0, dir_up←1, no tick. dir_toggle is ignored in the same cycle.
  - load: value←min(load_value, VALUE_MAX), prescaler←0, tick/wrap suppressed that cycle, state unchanged. A coincident start_stop is ignored.
- rst asserted mid-operation behaves identically to the reset values above on the next edge.

Optional Feature:
- Macro UPDOWN_BOUNCE_EN.
- When defined, the counter bounces instead of wrapping:
  - Up step at VALUE_MAX: value←VALUE_MAX-1, dir_up←0, wrap=1.
  - Down step at 0: value←1, dir_up←1, wrap=1.
  - If dir_toggle coincides with a bounce step, the bounce's direction change wins.
- When undefined: modulo wrap exactly as described in Behaviour.

Test Plan (TICK_MAX=3, VALUE_WIDTH=3, VALUE_MAX=5):
- rst, then start_stop pulse → running=1. tick every 4 clocks; value 1,2,3,4,5,0. wrap=1 only with 0. tick and wrap are single-cycle.
- At value 0, pulse dir_toggle, run → values 5,4,3; wrap on 5. dir_toggle coincident with a tick → that step still uses the old direction.
- RUN 2 clocks after a tick, start_stop, hold 10 clocks, start_stop → next tick after exactly 2 more RUN clocks. No tick/value change during HOLD.
- load with load_value=7 → value=5 (clamped). load coincident with the terminal count → value=load_value, no tick, next tick 4 clocks later.
- clear during RUN with dir_up=0 → next cycle: IDLE, value=0, dir_up=1, running=0. rst mid-HOLD → all outputs at reset values.
- With UPDOWN_BOUNCE_EN: from 0 counting up → 1,2,3,4,5,4,3,…,0,1. wrap on the steps to 4 (at top) and to 1 (at bottom). dir_up flips at those edges.
